alu_cmd_packer: RTL and testbench

ALU_CMD_PACKER -- requirements
Module: alu_cmd_packer

---
 rtl/alu_pkg.sv | 32 +++
 rtl/sat_counter.sv | 20 ++
 rtl/alu_cmd_packer.sv | 113 +++++++++++
 tb/tb_alu_cmd_packer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command packer: opcodes, command field layout,
// packer FSM states and a helper that assembles the 10-bit command word.
package alu_pkg;

    localparam int BYTE_W    = 8;
    localparam int OP_W      = 2;
    localparam int DATA_W    = 4;
    localparam int CMD_W     = OP_W + 2 * DATA_W;
    localparam int DATA1_LSB = 0;
    localparam int DATA2_LSB = DATA_W;
    localparam int OP_LSB    = 2 * DATA_W;

    typedef enum logic [OP_W-1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        MUL = 2'd2,
        DIV = 2'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        HDR,
        OPND,
        HOLD
    } packer_state_e;

    function automatic logic [CMD_W-1:0] pack_cmd(input alu_op_e op,
                                                  input logic [DATA_W-1:0] data2,
                                                  input logic [DATA_W-1:0] data1);
        return {op, data2, data1};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state is always updated with non-blocking assignments.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/alu_cmd_packer.sv
// Packs a two-byte host stream (header, operand) into one ALU command word.
// Optional ALU_DIV0_DROP_EN: reject DIV commands whose data2 is zero.
module alu_cmd_packer
    import alu_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [CMD_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err,
    output logic [CNT_W-1:0]  cmd_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    packer_state_e     state_q, state_d;
    alu_op_e           op_q;
    logic [DATA_W-1:0] data2_q, data1_q;
    logic              err_d;
    logic              latch_op, latch_opnd;
    logic              in_xfer, hdr_ok, div0_drop, cmd_done;

    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign in_xfer   = in_valid && in_ready;
    assign hdr_ok    = (in_data[BYTE_W-1:OP_W] == '0);
    assign cmd_done  = out_valid && out_ready;
    assign out_data  = pack_cmd(op_q, data2_q, data1_q);

`ifdef ALU_DIV0_DROP_EN
    assign div0_drop = (op_q == DIV) && (in_data[DATA2_LSB +: DATA_W] == '0);
`else
    assign div0_drop = 1'b0;
`endif

    // clear outranks a coincident byte: the byte is consumed and has no effect.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        err_d      = 1'b0;
        latch_op   = 1'b0;
        latch_opnd = 1'b0;
        unique case (state_q)
            HDR: begin
                if (!clear && in_xfer) begin
                    if (hdr_ok) begin
                        latch_op = 1'b1;
                        state_d  = OPND;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            OPND: begin
                if (clear) begin
                    state_d = HDR;
                end else if (in_xfer) begin
                    if (div0_drop) begin
                        err_d   = 1'b1;
                        state_d = HDR;
                    end else begin
                        latch_opnd = 1'b1;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) state_d = HDR;
            end
            default: state_d = HDR;
        endcase
    end

    // NOTE: the command fields are reset too, so out_data reads zero out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= HDR;
            err     <= 1'b0;
            op_q    <= ADD;
            data2_q <= '0;
            data1_q <= '0;
        end else begin
            state_q <= state_d;
            err     <= err_d;
            if (latch_op) op_q <= alu_op_e'(in_data[OP_W-1:0]);
            if (latch_opnd) begin
                data2_q <= in_data[DATA2_LSB +: DATA_W];
                data1_q <= in_data[DATA1_LSB +: DATA_W];
            end
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_cmd_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (cmd_done),
        .count (cmd_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_d),
        .count (err_cnt)
    );

endmodule

// File: tb/tb_alu_cmd_packer.sv
// Scoreboard bench for alu_cmd_packer: stimulus pushes expected commands, a
// negedge monitor pops and compares on every output handshake.
module tb_alu_cmd_packer;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             clear;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [9:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic             err;
    logic [CNT_W-1:0] cmd_cnt;
    logic [CNT_W-1:0] err_cnt;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [9:0] exp_q[$];
    int         exp_cmd  = 0;
    int         exp_err  = 0;
    logic       held     = 1'b0;
    logic [9:0] held_data;

    always #5 clk = ~clk;

    alu_cmd_packer #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .cmd_cnt   (cmd_cnt),
        .err_cnt   (err_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Waits for in_ready at a negedge, presents the byte, returns #1 after the transfer edge.
    task automatic send_byte(input logic [7:0] b, input logic clr = 1'b0);
        int budget = 0;
        @(negedge clk);
        while (!in_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 20) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stuck low for byte %0h", b);
        end
        in_data  = b;
        in_valid = 1'b1;
        clear    = clr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] hdr, input logic [7:0] opnd);
        send_byte(hdr);
        send_byte(opnd);
    endtask

    // Monitor: pop on handshake, and hold out_data steady while stalled.
    always @(negedge clk) begin
        if (reset) begin
            held = 1'b0;
        end else if (out_valid) begin
            if (held) check("hold_stable", out_data, held_data);
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", out_data, 10'h3ff ^ out_data);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                end
                held = 1'b0;
            end else begin
                held      = 1'b1;
                held_data = out_data;
            end
        end else begin
            held = 1'b0;
        end
    end

    initial begin
        logic [7:0] c0;
        reset     = 1'b1;
        clear     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data, 0);
        check("rst_err",       err, 0);
        check("rst_cmd_cnt",   cmd_cnt, 0);
        check("rst_err_cnt",   err_cnt, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1 check("rst_in_ready", in_ready, 1);

        // Basic command, latency 1
        exp_q.push_back(10'h053);
        send_cmd(8'h00, 8'h53);
        check("lat_out_valid", out_valid, 1);
        check("lat_out_data",  out_data, 10'h053);
        @(posedge clk); #1;
        exp_cmd++;
        check("cmd_cnt_1", cmd_cnt, exp_cmd);

        // Bad header
        send_byte(8'h06);
        exp_err++;
        check("bad_hdr_err",     err, 1);
        check("bad_hdr_err_cnt", err_cnt, exp_err);
        check("bad_hdr_noval",   out_valid, 0);
        @(posedge clk); #1;
        check("err_one_cycle", err, 0);
        exp_q.push_back(10'h121);
        send_cmd(8'h01, 8'h21);
        @(posedge clk); #1;
        exp_cmd++;

        // Backpressure for 10 cycles
        out_ready = 1'b0;
        exp_q.push_back(10'h234);
        send_cmd(8'h02, 8'h34);
        repeat (10) @(posedge clk);
        #1;
        check("stall_valid",    out_valid, 1);
        check("stall_in_ready", in_ready, 0);
        check("stall_data",     out_data, 10'h234);
        check("stall_cmd_cnt",  cmd_cnt, exp_cmd);
        out_ready = 1'b1;
        @(posedge clk); #1;
        exp_cmd++;
        check("stall_released", out_valid, 0);
        check("stall_cmd_cnt2", cmd_cnt, exp_cmd);

        // DIV with nonzero data2 always forwards; DIV by zero depends on the macro
        exp_q.push_back(10'h350);
        send_cmd(8'h03, 8'h50);
        @(posedge clk); #1;
        exp_cmd++;
`ifdef ALU_DIV0_DROP_EN
        send_cmd(8'h03, 8'h05);
        exp_err++;
        check("div0_err",   err, 1);
        check("div0_noval", out_valid, 0);
`else
        exp_q.push_back(10'h305);
        send_cmd(8'h03, 8'h05);
        check("div0_fwd", out_valid, 1);
        @(posedge clk); #1;
        exp_cmd++;
`endif
        check("div_cmd_cnt", cmd_cnt, exp_cmd);
        check("div_err_cnt", err_cnt, exp_err);

        // clear discards a latched header
        send_byte(8'h01);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        exp_q.push_back(10'h011);
        send_cmd(8'h00, 8'h11);
        @(posedge clk); #1;
        exp_cmd++;

        // clear coincident with a header transfer swallows it
        send_byte(8'h01, 1'b1);
        exp_q.push_back(10'h245);
        send_cmd(8'h02, 8'h45);
        @(posedge clk); #1;
        exp_cmd++;
        check("clear_cmd_cnt", cmd_cnt, exp_cmd);
        check("clear_err_cnt", err_cnt, exp_err);

        // Throughput: four commands in twelve cycles
        c0 = cmd_cnt;
        exp_q.push_back(10'h012);
        exp_q.push_back(10'h134);
        exp_q.push_back(10'h256);
        exp_q.push_back(10'h378);
        fork
            begin
                send_cmd(8'h00, 8'h12);
                send_cmd(8'h01, 8'h34);
                send_cmd(8'h02, 8'h56);
                send_cmd(8'h03, 8'h78);
            end
            begin
                repeat (12) @(posedge clk);
                #1;
                check("throughput", cmd_cnt, c0 + 8'd4);
            end
        join
        @(posedge clk); #1;

        // Reset while holding a command
        out_ready = 1'b0;
        send_cmd(8'h01, 8'h22);
        check("pre_rst_valid", out_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("rst_hold_valid",   out_valid, 0);
        check("rst_hold_cmd_cnt", cmd_cnt, 0);
        check("rst_hold_err_cnt", err_cnt, 0);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        exp_cmd   = 0;
        exp_err   = 0;
        @(posedge clk); #1;
        check("post_rst_valid", out_valid, 0);

        // Saturation of cmd_cnt
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            logic [1:0] op;
            logic [7:0] opnd;
            op   = 2'(i % 3);
            opnd = 8'(i);
            exp_q.push_back({op, opnd});
            send_cmd({6'b0, op}, opnd);
        end
        @(posedge clk); #1;
        check("sat_cmd_cnt", cmd_cnt, (1 << CNT_W) - 1);
        check("sat_err_cnt", err_cnt, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
